// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. Multi-beat packets lock the grant so that a packet
// lands in the FIFO contiguously. The datapath is combinational with zero
// latency. Only the arbitration state is registered.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          grant_vld,
  output logic                          locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;

  logic [ID_WIDTH-1:0]   winner;
  logic                  win_vld;
  logic [DATA_WIDTH-1:0] din_sel;
  logic                  win_last;

  // Increment the round-robin pointer. The explicit compare keeps the wrap
  // correct when NUM_REQ is not a power of two.
  function automatic logic [ID_WIDTH-1:0] ptr_inc(input logic [ID_WIDTH-1:0] p);
    return (p == ID_WIDTH'(NUM_REQ-1)) ? '0 : p + 1'b1;
  endfunction

  // Winner selection: the locked owner, or the first valid requester at or
  // after rr_ptr (wrapping).
  always_comb begin
    int                  idx;
    logic [ID_WIDTH-1:0] cand;
    winner  = '0;
    win_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    if (state_q == LOCKED) begin
      winner  = lock_id_q;
      win_vld = req_valid[lock_id_q];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
        cand = ID_WIDTH'(idx);
        if (!win_vld && req_valid[cand]) begin
          win_vld = 1'b1;
          winner  = cand;
        end
      end
    end
  end

  // Data and last-flag mux for the winning requester.
  always_comb begin
    din_sel  = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_WIDTH'(i)) begin
        din_sel  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        win_last = req_last[i];
      end
    end
  end

  // Output handshake. Gating with rst_n forces the outputs quiet while
  // reset is asserted, independent of the requester inputs.
  always_comb begin
    grant_vld = rst_n & win_vld;
    fifo_wr   = grant_vld & ~fifo_full;
    fifo_din  = rst_n ? din_sel : '0;
    grant_id  = grant_vld ? winner : '0;
    locked    = (state_q == LOCKED);
    req_ready = '0;
    if (fifo_wr) req_ready[winner] = 1'b1;
  end

  // Next-state logic. State changes only on an accepted beat.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (fifo_wr) begin
      case (state_q)
        IDLE: begin
          if (win_last) begin
            rr_ptr_d = ptr_inc(winner);
          end else begin
            state_d   = LOCKED;
            lock_id_d = winner;
          end
        end
        LOCKED: begin
          if (win_last) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(lock_id_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbitration state registers. Asserting reset abandons any lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Per-requester beat queues drive the
// inputs. The expected FIFO write stream is pushed into a scoreboard, and a
// negedge monitor pops and compares each write.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr;
  logic [DW-1:0]    fifo_din;
  logic [IW-1:0]    grant_id;
  logic             grant_vld;
  logic             locked;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_din(fifo_din), .grant_id(grant_id), .grant_vld(grant_vld),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] d; logic lk; } exp_t;

  beat_t src [NR][$];
  exp_t  exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    wr_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input int id, input logic [DW-1:0] d, input logic lk);
    exp_t e;
    e.id = IW'(id); e.d = d; e.lk = lk;
    exp_q.push_back(e);
  endtask

  task automatic load(input int id, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    src[id].push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = src[i][0].l;
        req_data[i*DW +: DW] = src[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // One clock. The ready seen at negedge tells which beats the edge accepts.
  task automatic step();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i]) begin
        void'(src[i].pop_front());
        wr_count++;
      end
    drive();
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NR; i++) if (src[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string nm, input int budget);
    int n = 0;
    drive();
    while (any_pending() && n < budget) begin step(); n++; end
    chk({nm, "_timeout"}, 32'(any_pending()), 32'd0);
    chk({nm, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_wr(input string nm, input int target, input int budget);
    int n = 0;
    drive();
    while (wr_count < target && n < budget) begin step(); n++; end
    chk({nm, "_wait_timeout"}, 32'(wr_count >= target), 32'd1);
  endtask

  // Monitor: every write must match the next scoreboard entry. Ready stays
  // low whenever there is no write.
  always @(negedge clk) begin
    if (fifo_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", fifo_din, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_data", fifo_din, e.d);
        chk("wr_grant_id", 32'(grant_id), 32'(e.id));
        chk("wr_ready", 32'(req_ready), 32'(4'b0001 << e.id));
        chk("wr_locked", 32'(locked), 32'(e.lk));
      end
    end else begin
      chk("idle_ready_zero", 32'(req_ready), 32'd0);
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; fifo_full = 1'b0;
    req_valid = '1; req_last = '1;
    req_data = {32'h33, 32'h22, 32'h11, 32'h55};
    #3;
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_vld", 32'(grant_vld), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_fifo_din", fifo_din, 32'd0);
    drive();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Single-beat round robin
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < NR; i++) begin
        load(i, 32'(16*i + b), 1'b1);
        push(i, 32'(16*i + b), 1'b0);
      end
    drain("rr", 40);

    // Packet lock: move rr_ptr to 1 first, then req1 packet vs req0/req2
    load(0, 32'h0F, 1'b1); push(0, 32'h0F, 1'b0);
    drain("lock_pre", 10);
    load(1, 32'hA1, 1'b0); load(1, 32'hA2, 1'b0); load(1, 32'hA3, 1'b1);
    load(0, 32'hB0, 1'b1); load(2, 32'hC2, 1'b1);
    push(1, 32'hA1, 1'b0); push(1, 32'hA2, 1'b1); push(1, 32'hA3, 1'b1);
    push(2, 32'hC2, 1'b0); push(0, 32'hB0, 1'b0);
    drain("lock", 20);

    // Backpressure mid-packet on req3
    base = wr_count;
    load(3, 32'hD0, 1'b0); load(3, 32'hD1, 1'b0);
    load(3, 32'hD2, 1'b0); load(3, 32'hD3, 1'b1);
    push(3, 32'hD0, 1'b0); push(3, 32'hD1, 1'b1);
    push(3, 32'hD2, 1'b1); push(3, 32'hD3, 1'b1);
    wait_wr("bp", base + 2, 10);
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_fifo_wr", 32'(fifo_wr), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_grant_id", 32'(grant_id), 32'd3);
      chk("bp_grant_vld", 32'(grant_vld), 32'd1);
      @(posedge clk);
    end
    #1 fifo_full = 1'b0;
    base = wr_count;
    step();
    chk("bp_resume", 32'(wr_count), 32'(base + 1));
    drain("bp", 10);

    // Lock gap: rr_ptr to 2 via req1, then req2 packet with a 4-cycle hole
    load(1, 32'h1F, 1'b1); push(1, 32'h1F, 1'b0);
    drain("gap_pre", 10);
    base = wr_count;
    load(2, 32'hE0, 1'b0); load(0, 32'hF0, 1'b1);
    push(2, 32'hE0, 1'b0); push(2, 32'hE1, 1'b1); push(0, 32'hF0, 1'b0);
    wait_wr("gap", base + 1, 10);
    repeat (4) begin
      @(negedge clk);
      chk("gap_fifo_wr", 32'(fifo_wr), 32'd0);
      chk("gap_grant_vld", 32'(grant_vld), 32'd0);
      chk("gap_locked", 32'(locked), 32'd1);
      @(posedge clk);
    end
    #1 load(2, 32'hE1, 1'b1);
    drain("gap", 10);

    // Async reset while locked on req1
    base = wr_count;
    load(1, 32'h60, 1'b0); load(1, 32'h61, 1'b0);
    push(1, 32'h60, 1'b0);
    wait_wr("arst", base + 1, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_grant_vld", 32'(grant_vld), 32'd0);
    src[1].delete();
    load(0, 32'h70, 1'b1); load(1, 32'h71, 1'b1);
    push(0, 32'h70, 1'b0); push(1, 32'h71, 1'b0);
    drive();
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
    #1;
    chk("arst_rel_locked", 32'(locked), 32'd0);
    chk("arst_rel_grant", 32'(grant_id), 32'd0);
    drain("arst", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one write port of the `fifo` block (wr/din/full interface) among NUM_REQ producers.
- Arbitration is round-robin with packet locking: a multi-beat packet is written to the FIFO contiguously, with no interleaving from other requesters.
- Sits directly in front of `fifo`: drives its wr/din and observes its full.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, width of each requester's data and of the FIFO din.
- ID_WIDTH, 2, width of the grant index (must equal clog2(NUM_REQ)).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester last-beat-of-packet flag, qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle.
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr  out  1  FIFO write strobe.
- fifo_din  out  DATA_WIDTH  FIFO write data.
- grant_id  out  ID_WIDTH  index of the requester currently selected (valid when grant_vld=1).
- grant_vld  out  1  some requester is selected this cycle.
- locked  out  1  arbiter is in LOCKED state.

Behaviour:
- States: IDLE, LOCKED. Registered state: state, rr_ptr (ID_WIDTH), lock_id (ID_WIDTH).
- Reset (rst_n=0, asynchronous): state=IDLE, rr_ptr=0, lock_id=0. While rst_n=0, fifo_wr=0, req_ready=0, grant_vld=0 and locked=0, forced regardless of the inputs. grant_id=0 and fifo_din=0.
- Selection in IDLE is combinational: the winner is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0. grant_vld=|req_valid.
- Selection in LOCKED: winner = lock_id. grant_vld=req_valid[lock_id]. Other requesters are never served.
- Datapath, combinational, zero latency:
  - fifo_din = req_data of the winner.
  - fifo_wr = grant_vld & ~fifo_full.
  - req_ready[i] = fifo_wr & (i == winner).
  - No other requester's ready is ever asserted.
- Handshake: a beat transfers when req_valid[i] & req_ready[i]. Requesters hold valid, data and last stable until accepted. The arbiter neither drops nor duplicates beats.
- Transitions on an accepted beat (fifo_wr=1) from winner w:
  - IDLE, last=1: stay IDLE; rr_ptr <= w+1 (mod NUM_REQ).
  - IDLE, last=0: go LOCKED; lock_id <= w.
  - LOCKED, last=0: stay LOCKED.
  - LOCKED, last=1: go IDLE; rr_ptr <= lock_id+1 (mod NUM_REQ).
- No accepted beat: no state change. This covers fifo_full=1, no valid, and a LOCKED requester dropping valid mid-packet. The lock persists indefinitely; gaps inside a packet are legal.
- fifo_full=1: no write and no state or pointer update. The winner is still reported on grant_id, and the grant does not move while full.
- rr_ptr wrap: NUM_REQ-1 + 1 -> 0. For non-power-of-two NUM_REQ, explicit compare, not natural overflow.
- locked = (state==LOCKED). grant_id = winner index (0 when grant_vld=0).
- Reset asserted mid-packet: the lock is abandoned. After release the arbiter is IDLE with rr_ptr=0, and the partial packet already in the FIFO is not recalled.
- Throughput: one beat per cycle when not full. There is no bubble between back-to-back packets from different requesters.

Test Plan:
- Single-beat round robin: NUM_REQ=4, all valid, all last=1, data=0x10*i+beat, FIFO never full -> FIFO receives 0x00,0x10,0x20,0x30,0x01,0x11,... one per cycle; rr_ptr cycles 1,2,3,0.
- Packet lock: req1 sends a 3-beat packet (A1,A2,A3, last on A3) while req0/req2 are valid with single beats -> FIFO order A1,A2,A3,then req2,then req0. locked=1 for exactly the two cycles following acceptance of A1 and A2.
- Backpressure: fifo_full held high for 5 cycles mid-packet of req3 -> fifo_wr=0, req_ready=0, grant_id=3 throughout; the packet resumes in the cycle full drops; no beat is lost or duplicated.
- Lock gap: req2 drops valid for 4 cycles between beats 1 and 2 of a packet while req0 is valid -> req0 is not served until req2's last beat is accepted; the next grant is req0 (rr_ptr=3, search wraps to 0).
- Async reset mid-packet: assert rst_n=0 between clock edges during LOCKED on req1 -> outputs immediately fifo_wr=0, req_ready=0, locked=0. After release with req0 and req1 both valid, req0 wins first.
- End-to-end with `fifo` (LOOKAHEAD=1): 4 requesters, random valid, random packets of 1..8 beats, random reads -> per-requester FIFO output order matches the send order, packets are contiguous, and there are no x on dout.
